// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned NSEG = 5;

  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_PD  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  typedef enum logic {
    ST_RUN,
    ST_WAIT_IF
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_BP,
    CAUSE_EXC
  } cause_e;

endpackage

// File: rtl/pipe_ctrl_stall_encode.sv
// Priority encoder: the highest stalled stage holds every segment below it
// and inserts a bubble into its own segment.
module pipe_stall_encode #(
  parameter int unsigned NSEG = 5
) (
  input  logic [NSEG-1:0] i_stall_req,
  output logic [NSEG-1:0] o_seg_stall,
  output logic [NSEG-1:0] o_seg_refresh
);

  // Later (higher) set bits overwrite earlier ones, leaving the highest winner.
  always_comb begin
    o_seg_stall   = '0;
    o_seg_refresh = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (i_stall_req[i]) begin
        o_seg_refresh    = '0;
        o_seg_refresh[i] = 1'b1;
        o_seg_stall      = '0;
        for (int unsigned j = 0; j < i; j++) begin
          o_seg_stall[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: segment stall/refresh, fetch redirect with
// a pending slot while fetch is busy, and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned NSEG     = pipe_ctrl_pkg::NSEG,
  parameter logic [31:0] RESET_PC = pipe_ctrl_pkg::RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSEG-1:0]  stall_req,
  input  logic             ec_bp_fail,
  input  logic [31:0]      ec_target,
  input  logic             exc_valid,
  input  logic [31:0]      exc_vector,
  input  logic             if_busy,
  output logic [NSEG-1:0]  seg_stall,
  output logic [NSEG-1:0]  seg_refresh,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fail_flushed,
  output logic [CNT_W-1:0] stall_cnt
);
  import pipe_ctrl_pkg::*;

  logic [NSEG-1:0] w_enc_stall;
  logic [NSEG-1:0] w_enc_refresh;
  logic            w_exc_acc;
  logic            w_bp_acc;
  cause_e          w_cause;
  logic [31:0]     w_target;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [31:0]     r_pend_pc;
  logic [31:0]     w_pend_pc_nxt;
  cause_e          r_pend_cause;
  cause_e          w_pend_cause_nxt;
  logic [31:0]     r_last_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic            r_fail_flushed;

  pipe_stall_encode #(
    .NSEG(NSEG)
  ) u_encode (
    .i_stall_req   (stall_req),
    .o_seg_stall   (w_enc_stall),
    .o_seg_refresh (w_enc_refresh)
  );

  // Accept exceptions only while MEM is not blocked; exception beats mispredict.
  always_comb begin
    w_exc_acc = exc_valid & ~stall_req[NSEG-1];
    w_bp_acc  = ec_bp_fail & ~w_exc_acc;
    if (w_exc_acc) begin
      w_cause  = CAUSE_EXC;
      w_target = exc_vector;
    end else if (w_bp_acc) begin
      w_cause  = CAUSE_BP;
      w_target = ec_target;
    end else begin
      w_cause  = CAUSE_NONE;
      w_target = ec_target;
    end
  end

  // FSM state and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pend_pc    <= RESET_PC;
      r_pend_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_pend_cause <= w_pend_cause_nxt;
    end
  end

  // Next state and pending target; a busy fetch parks the redirect in pend_pc.
  always_comb begin
    w_state_nxt      = r_state;
    w_pend_pc_nxt    = r_pend_pc;
    w_pend_cause_nxt = r_pend_cause;
    case (r_state)
      ST_RUN: begin
        if (w_cause != CAUSE_NONE && if_busy) begin
          w_state_nxt      = ST_WAIT_IF;
          w_pend_pc_nxt    = w_target;
          w_pend_cause_nxt = w_cause;
        end
      end
      ST_WAIT_IF: begin
        if (w_exc_acc) begin
          w_pend_pc_nxt    = exc_vector;
          w_pend_cause_nxt = CAUSE_EXC;
        end else if (w_bp_acc && r_pend_cause != CAUSE_EXC) begin
          w_pend_pc_nxt    = ec_target;
          w_pend_cause_nxt = CAUSE_BP;
        end
        if (!if_busy) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs: segment controls and redirect pulse/target.
  always_comb begin
    seg_stall      = '0;
    seg_refresh    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = r_last_pc;

    if (reset) begin
      seg_refresh = '1;
    end else if (w_exc_acc) begin
      seg_refresh = '1;
    end else begin
      seg_refresh = w_enc_refresh;
      if (w_bp_acc) begin
        seg_refresh[STG_IF] = 1'b1;
        seg_refresh[STG_PD] = 1'b1;
      end
      if (r_state == ST_WAIT_IF) begin
        seg_refresh[STG_IF] = 1'b1;
      end
      seg_stall = w_enc_stall & ~seg_refresh;
    end

    // A cause arriving on the release cycle is merged into the pending
    // target first, so the pulse carries the winning cause.
    if (reset) begin
      redirect_pc = RESET_PC;
    end else if (r_state == ST_RUN) begin
      if (w_cause != CAUSE_NONE && !if_busy) begin
        redirect_valid = 1'b1;
        redirect_pc    = w_target;
      end
    end else if (!if_busy) begin
      redirect_valid = 1'b1;
      redirect_pc    = w_pend_pc_nxt;
    end
  end

  // Stall counter, mispredict flag and the held redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt    <= '0;
      r_fail_flushed <= 1'b0;
      r_last_pc      <= RESET_PC;
    end else begin
      if (|seg_stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      r_fail_flushed <= w_bp_acc;
      if (redirect_valid) begin
        r_last_pc <= redirect_pc;
      end
    end
  end

  assign stall_cnt    = r_stall_cnt;
  assign fail_flushed = r_fail_flushed;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five pipeline segment registers (if_pd, pd_id, id_ex, ex_mem, mem_wb).
- Collects per-stage stall requests, branch-mispredict reports from EX and exceptions from MEM.
- Drives every segment's `stall` and `refresh` inputs.
- Owns the fetch redirect, holding it pending while the instruction fetch side has a request outstanding.
- Counts stall cycles for performance monitoring.

## Interface
- `NSEG`, 5: number of segment registers; segment i latches the output of stage i (0=IF, 1=PD, 2=ID, 3=EX, 4=MEM).
- `RESET_PC`, 32'hBFC00000: value of `redirect_pc` in reset.
- `CNT_W`, 32: stall counter width.

- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall_req`  in  NSEG: bit i is set when stage i cannot complete this cycle (0 icache, 2 load-use, 3 div busy, 4 dcache).
- `ec_bp_fail`  in  1: EX reports a mispredicted branch this cycle.
- `ec_target`  in  32: correct target for `ec_bp_fail`.
- `exc_valid`  in  1: MEM reports an exception or ERET. Held by the source until acted on.
- `exc_vector`  in  32: handler or EPC address.
- `if_busy`  in  1: fetch has an outstanding icache/AXI request.
- `seg_stall`  out  NSEG: hold segment i.
- `seg_refresh`  out  NSEG: clear segment i to a bubble.
- `redirect_valid`  out  1: one-cycle pulse to load `redirect_pc` into the fetch PC.
- `redirect_pc`  out  32: redirect target.
- `fail_flushed`  out  1: registered copy of an accepted `ec_bp_fail`.
- `stall_cnt`  out  CNT_W: saturating count of cycles with any `seg_stall` bit set.

## Operation
**Stall propagation**
- k = highest index with `stall_req[k]` set.
- `seg_stall[j]` = 1 for j < k.
- `seg_refresh[k]` = 1, giving a bubble behind the blocked stage.
- Segments above k advance.
- No request set: all segments advance.

**Exception** (accepted only when `stall_req[4]` = 0)
- `seg_refresh[0..4]` = 1.
- All stalls are masked.
- Redirect cause = exception, target = `exc_vector`.
- While `stall_req[4]` = 1, `exc_valid` has no effect.

**Mispredict** (`ec_bp_fail`)
- `seg_refresh[0]` and `seg_refresh[1]` = 1. The delay slot in ID proceeds.
- Redirect target = `ec_target`.
- Segments 2..4 follow normal stall propagation.
- Ignored in a cycle where an exception is accepted.

**Priority**
- `seg_refresh` overrides `seg_stall` on the same bit.
- Exception overrides mispredict.

**FSM**
- RUN, on an accepted redirect cause:
  - `if_busy` = 0: `redirect_valid` = 1 in the same cycle; stay in RUN.
  - `if_busy` = 1: latch target into `pend_pc`; go to WAIT_IF.
- WAIT_IF:
  - `seg_refresh[0]` = 1 every cycle.
  - An accepted exception overwrites `pend_pc`.
  - An accepted mispredict overwrites `pend_pc` only if the pending cause is not an exception.
  - On the first cycle with `if_busy` = 0: `redirect_valid` = 1, `redirect_pc` = `pend_pc`, next state RUN.

**`redirect_pc` mux**
- RUN: the direct target.
- WAIT_IF: `pend_pc`.
- Outside a pulse: last value driven.

**Counters and flags**
- `stall_cnt` increments when any `seg_stall` bit is set and saturates at all-ones.
- `fail_flushed` <= accepted `ec_bp_fail`.

## Timing
- `seg_stall`/`seg_refresh` are combinational from inputs, valid in the same cycle, and take effect at the next edge.
- Redirect latency:
  - 0 cycles if `if_busy` = 0.
  - Otherwise N cycles, where `if_busy` falls after N cycles in WAIT_IF.
- `redirect_valid` is never high for two consecutive cycles from a single cause.

**Reset (`reset` high)**
- `seg_refresh` = all ones, `seg_stall` = 0.
- `redirect_valid` = 0, `redirect_pc` = RESET_PC.
- State RUN, `pend_pc` = RESET_PC.
- `stall_cnt` = 0, `fail_flushed` = 0.
- Reset in WAIT_IF drops the pending redirect.

## Structure
- Shared package/header: `NSEG`, stage index constants (STG_IF..STG_MEM), FSM state encoding, redirect cause encoding (CAUSE_NONE/BP/EXC), RESET_PC.
- One natural sub-module, `pipe_stall_encode`: priority encoder from `stall_req` to `seg_stall`/`seg_refresh`. It is purely combinational and instantiated once.

## Test plan
- `stall_req` = 5'b00100 for 2 cycles -> `seg_stall` = 5'b00011 and `seg_refresh` = 5'b00100 both cycles; `stall_cnt` = 2.
- `stall_req` = 5'b10100 -> `seg_stall` = 5'b01111, `seg_refresh` = 5'b10000.
- `ec_bp_fail` = 1, `ec_target` = 32'h80001000, `if_busy` = 0 -> same cycle: `redirect_valid` = 1, `seg_refresh[1:0]` = 2'b11. Next cycle: `fail_flushed` = 1.
- `ec_bp_fail` (target 32'h80001000) with `if_busy` = 1 for 3 cycles, and `exc_valid` (vector 32'hBFC00380) in WAIT_IF cycle 2 -> single `redirect_valid` pulse with pc 32'hBFC00380 when `if_busy` falls.
- `exc_valid` = 1 with `stall_req[4]` = 1 for 4 cycles -> no refresh or redirect. First cycle `stall_req[4]` = 0 -> `seg_refresh` = 5'b11111 and redirect to `exc_vector`.
- `reset` asserted in WAIT_IF -> no `redirect_valid`, `seg_refresh` = 5'b11111, `stall_cnt` = 0, RUN after release.
